// File: rtl/pc_unit.sv
// Program-counter unit: PC register, next-address mux and an internal return-address stack.
// Optional macro RAS_ERR_EN: sticky STK_ERR port, and pushes onto a full stack are dropped (not circular).
module pc_unit #(
    parameter int               WIDTH      = 10,
    parameter logic [WIDTH-1:0] ISR_ADDR   = '1,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0,
    parameter int               STK_DEPTH  = 8
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             PC_LD,
    input  logic                             PC_INC,
    input  logic [1:0]                       PC_MUX_SEL,
    input  logic [WIDTH-1:0]                 FROM_IMMED,
    input  logic                             PUSH,
    input  logic                             POP,
    output logic [WIDTH-1:0]                 PC_COUNT,
    output logic [WIDTH-1:0]                 STK_TOP,
    output logic [$clog2(STK_DEPTH+1)-1:0]   STK_CNT,
    output logic                             STK_EMPTY,
`ifdef RAS_ERR_EN
    output logic                             STK_FULL,
    output logic                             STK_ERR
`else
    output logic                             STK_FULL
`endif
);
    localparam int               CNT_W    = $clog2(STK_DEPTH + 1);
    localparam int               PTR_W    = $clog2(STK_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STK_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(STK_DEPTH - 1);

    logic [WIDTH-1:0] stk_mem [STK_DEPTH];
    logic [PTR_W-1:0] ptr, ptr_inc, ptr_dec, ptr_nxt, wr_idx;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             stk_wr;
    logic [WIDTH-1:0] ret_addr, next_addr;
`ifdef RAS_ERR_EN
    logic             err, err_set;
`endif

    assign ret_addr  = PC_COUNT + 1'b1;
    assign STK_CNT   = cnt;
    assign STK_EMPTY = (cnt == '0);
    assign STK_FULL  = (cnt == CNT_MAX);
    // Masked while empty so stale or never-written entries never leak out.
    assign STK_TOP   = STK_EMPTY ? RESET_ADDR : stk_mem[ptr];
`ifdef RAS_ERR_EN
    assign STK_ERR   = err;
`endif

    // ptr indexes the current top; wrap explicitly so non-power-of-2 depths work.
    assign ptr_inc = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    assign ptr_dec = (ptr == '0) ? PTR_LAST : ptr - 1'b1;

    always_comb begin
        case (PC_MUX_SEL)
            2'b00:   next_addr = FROM_IMMED;
            2'b01:   next_addr = STK_TOP;
            2'b10:   next_addr = ISR_ADDR;
            default: next_addr = RESET_ADDR;
        endcase
    end

    always_comb begin
        stk_wr  = 1'b0;
        wr_idx  = ptr_inc;
        ptr_nxt = ptr;
        cnt_nxt = cnt;
`ifdef RAS_ERR_EN
        err_set = 1'b0;
`endif
        if (PUSH && POP && !STK_EMPTY) begin
            stk_wr = 1'b1;
            wr_idx = ptr;
        end else if (PUSH) begin
            if (!STK_FULL) begin
                stk_wr  = 1'b1;
                ptr_nxt = ptr_inc;
                cnt_nxt = cnt + 1'b1;
            end else begin
`ifdef RAS_ERR_EN
                err_set = 1'b1;
`else
                // When full, the slot after top holds the oldest entry.
                stk_wr  = 1'b1;
                ptr_nxt = ptr_inc;
`endif
            end
        end else if (POP) begin
            if (!STK_EMPTY) begin
                ptr_nxt = ptr_dec;
                cnt_nxt = cnt - 1'b1;
            end
`ifdef RAS_ERR_EN
            else begin
                err_set = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            PC_COUNT <= RESET_ADDR;
            cnt      <= '0;
            ptr      <= PTR_LAST;
`ifdef RAS_ERR_EN
            err      <= 1'b0;
`endif
        end else begin
            if (PC_LD)
                PC_COUNT <= next_addr;
            else if (PC_INC)
                PC_COUNT <= PC_COUNT + 1'b1;
            cnt <= cnt_nxt;
            ptr <= ptr_nxt;
`ifdef RAS_ERR_EN
            if (err_set)
                err <= 1'b1;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (stk_wr && !RST)
            stk_mem[wr_idx] <= ret_addr;
    end

endmodule
